wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_if.sv | 38 +++
 rtl/wb_stage.sv | 74 +++++++
 tb/tb_wb_stage.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// MEM/WB-to-writeback bundle: retiring-instruction fields in, register-file write port,
// halt/display status and performance counters out.
interface wb_stage_if;
    logic [31:0] sel1;
    logic [31:0] sel2;
    logic [31:0] PC_jal;
    logic        ld;
    logic        we;
    logic        syscall;
    logic        jal;
    logic [4:0]  Rw;
    logic        valid;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        go;

    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic        wb_we;
    logic        halt;
    logic [31:0] disp_data;
    logic        disp_valid;
    logic [31:0] instr_cnt;
    logic [31:0] cycle_cnt;
    logic [15:0] syscall_cnt;

    modport master (
        output sel1, sel2, PC_jal, ld, we, syscall, jal, Rw, valid, v0, a0, go,
        input  wb_data, wb_addr, wb_we, halt, disp_data, disp_valid,
               instr_cnt, cycle_cnt, syscall_cnt
    );

    modport slave (
        input  sel1, sel2, PC_jal, ld, we, syscall, jal, Rw, valid, v0, a0, go,
        output wb_data, wb_addr, wb_we, halt, disp_data, disp_valid,
               instr_cnt, cycle_cnt, syscall_cnt
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: selects register-file write data, handles halt/display syscalls and
// keeps retired-instruction, cycle and syscall counters.
module wb_stage #(
    parameter logic [31:0] HALT_CODE = 32'd10,
    parameter logic [31:0] DISP_CODE = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    wb_stage_if.slave   bus
);

    typedef enum logic {StRun = 1'b0, StHalt = 1'b1} state_e;

    state_e      state_q;
    logic [31:0] disp_data_q;
    logic        disp_valid_q;
    logic [31:0] instr_cnt_q;
    logic [31:0] cycle_cnt_q;
    logic [15:0] syscall_cnt_q;

    logic        sys_fire;

    always_comb begin
        bus.wb_data = bus.jal ? bus.PC_jal : (bus.ld ? bus.sel2 : bus.sel1);
        bus.wb_addr = bus.jal ? 5'd31 : bus.Rw;
        bus.wb_we   = bus.we & bus.valid & (state_q == StRun) & (bus.wb_addr != 5'd0);
    end

    assign sys_fire = bus.valid & bus.syscall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StRun;
            disp_data_q   <= 32'd0;
            disp_valid_q  <= 1'b0;
            instr_cnt_q   <= 32'd0;
            cycle_cnt_q   <= 32'd0;
            syscall_cnt_q <= 16'd0;
        end else begin
            disp_valid_q <= 1'b0;
            unique case (state_q)
                StRun: begin
                    cycle_cnt_q <= cycle_cnt_q + 32'd1;
                    if (bus.valid) begin
                        instr_cnt_q <= instr_cnt_q + 32'd1;
                    end
                    if (sys_fire) begin
                        syscall_cnt_q <= syscall_cnt_q + 16'd1;
                        // Halt wins if both codes are configured equal.
                        if (bus.v0 == HALT_CODE) begin
                            state_q <= StHalt;
                        end else if (bus.v0 == DISP_CODE) begin
                            disp_data_q  <= bus.a0;
                            disp_valid_q <= 1'b1;
                        end
                    end
                end
                StHalt: begin
                    if (bus.go) begin
                        state_q <= StRun;
                    end
                end
            endcase
        end
    end

    assign bus.halt        = (state_q == StHalt);
    assign bus.disp_data   = disp_data_q;
    assign bus.disp_valid  = disp_valid_q;
    assign bus.instr_cnt   = instr_cnt_q;
    assign bus.cycle_cnt   = cycle_cnt_q;
    assign bus.syscall_cnt = syscall_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized bench for wb_stage against a behavioural model of the writeback rules,
// plus directed cases for forwarding, halt/resume, display, wrap and async reset.
module tb_wb_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_stage_if bus();

    wb_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Model state: halted flag, last shown value, pulse, counters (wrap by width).
    logic        m_halt;
    logic [31:0] m_disp;
    logic        m_dv;
    logic [31:0] m_instr;
    logic [31:0] m_cyc;
    logic [15:0] m_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_halt  = 1'b0;
        m_disp  = 32'd0;
        m_dv    = 1'b0;
        m_instr = 32'd0;
        m_cyc   = 32'd0;
        m_sys   = 16'd0;
    endtask

    // One rising edge of the architectural rules.
    task automatic model_step();
        m_dv = 1'b0;
        if (m_halt) begin
            if (bus.go) m_halt = 1'b0;
        end else begin
            m_cyc = m_cyc + 1;
            if (bus.valid) begin
                m_instr = m_instr + 1;
                if (bus.syscall) begin
                    m_sys = m_sys + 1;
                    if (bus.v0 == 32'd10) begin
                        m_halt = 1'b1;
                    end else if (bus.v0 == 32'd1) begin
                        m_disp = bus.a0;
                        m_dv   = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_comb();
        logic [31:0] e_data;
        logic [4:0]  e_addr;
        logic        e_we;
        e_data = bus.jal ? bus.PC_jal : (bus.ld ? bus.sel2 : bus.sel1);
        e_addr = bus.jal ? 5'd31 : bus.Rw;
        e_we   = bus.we && bus.valid && !m_halt && (e_addr != 5'd0);
        check("wb_data", bus.wb_data, e_data);
        check("wb_addr", 32'(bus.wb_addr), 32'(e_addr));
        check("wb_we", 32'(bus.wb_we), 32'(e_we));
    endtask

    task automatic check_regs();
        check("halt", 32'(bus.halt), 32'(m_halt));
        check("disp_data", bus.disp_data, m_disp);
        check("disp_valid", 32'(bus.disp_valid), 32'(m_dv));
        check("instr_cnt", bus.instr_cnt, m_instr);
        check("cycle_cnt", bus.cycle_cnt, m_cyc);
        check("syscall_cnt", 32'(bus.syscall_cnt), 32'(m_sys));
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic tick();
        #1 check_comb();
        @(posedge clk);
        model_step();
        #1 check_regs();
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus.sel1 = 32'd0; bus.sel2 = 32'd0; bus.PC_jal = 32'd0;
        bus.ld = 1'b0; bus.we = 1'b0; bus.syscall = 1'b0; bus.jal = 1'b0;
        bus.Rw = 5'd0; bus.valid = 1'b0; bus.v0 = 32'd0; bus.a0 = 32'd0; bus.go = 1'b0;
    endtask

    task automatic rand_inputs();
        bus.sel1    = $urandom;
        bus.sel2    = $urandom;
        bus.PC_jal  = $urandom;
        bus.ld      = 1'($urandom_range(0, 1));
        bus.we      = 1'($urandom_range(0, 1));
        bus.jal     = ($urandom_range(0, 5) == 0);
        bus.Rw      = 5'($urandom_range(0, 31));
        bus.valid   = ($urandom_range(0, 3) != 0);
        bus.syscall = ($urandom_range(0, 3) == 0);
        bus.a0      = $urandom;
        bus.go      = ($urandom_range(0, 2) == 0);
        case ($urandom_range(0, 3))
            0:       bus.v0 = 32'd1;
            1:       bus.v0 = 32'd10;
            default: bus.v0 = $urandom;
        endcase
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        model_reset();
        #1 check_regs();
        rst = 1'b1;
    endtask

    initial begin
        set_idle();
        bus.we = 1'b1; bus.valid = 1'b1; bus.Rw = 5'd7;
        rst = 1'b0;
        model_reset();
        #2 check_regs();
        check_comb();
        check("rst_wb_we", 32'(bus.wb_we), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        set_idle();

        // Data/address selection and jal priority.
        bus.ld = 1'b1; bus.sel2 = 32'hDEAD_0000; bus.sel1 = 32'h1; bus.Rw = 5'd8;
        bus.we = 1'b1; bus.valid = 1'b1;
        #1 check("ld_data", bus.wb_data, 32'hDEAD_0000);
        check("ld_addr", 32'(bus.wb_addr), 32'd8);
        check("ld_we", 32'(bus.wb_we), 32'd1);
        bus.jal = 1'b1; bus.PC_jal = 32'h400C;
        #1 check("jal_data", bus.wb_data, 32'h400C);
        check("jal_addr", 32'(bus.wb_addr), 32'd31);
        tick();

        // Writes to r0 and bubbles never enable the register file.
        bus.jal = 1'b0; bus.Rw = 5'd0;
        #1 check("r0_we", 32'(bus.wb_we), 32'd0);
        bus.valid = 1'b0; bus.Rw = 5'd5;
        #1 check("bubble_we", 32'(bus.wb_we), 32'd0);
        tick();

        // Display syscall.
        set_idle();
        bus.valid = 1'b1; bus.syscall = 1'b1; bus.v0 = 32'd1; bus.a0 = 32'h1234;
        tick();
        check("disp_d", bus.disp_data, 32'h1234);
        check("disp_v1", 32'(bus.disp_valid), 32'd1);
        check("disp_sys", 32'(bus.syscall_cnt), 32'd1);
        set_idle();
        tick();
        check("disp_v0", 32'(bus.disp_valid), 32'd0);

        // Halt after five instructions, freeze, then resume.
        pulse_reset();
        set_idle();
        bus.valid = 1'b1;
        repeat (5) tick();
        bus.syscall = 1'b1; bus.v0 = 32'd10; bus.we = 1'b1; bus.Rw = 5'd2;
        #1 check("halt_sys_we", 32'(bus.wb_we), 32'd1);
        tick();
        check("halted", 32'(bus.halt), 32'd1);
        check("halt_instr", bus.instr_cnt, 32'd6);
        check("halt_sys", 32'(bus.syscall_cnt), 32'd1);
        bus.v0 = 32'd1; bus.Rw = 5'd3;
        repeat (10) tick();
        check("frozen_instr", bus.instr_cnt, 32'd6);
        check("frozen_cyc", bus.cycle_cnt, 32'd6);
        set_idle();
        bus.go = 1'b1;
        tick();
        check("resumed", 32'(bus.halt), 32'd0);
        bus.go = 1'b0; bus.valid = 1'b1;
        tick();
        check("resume_instr", bus.instr_cnt, 32'd7);

        // Cycle counter wrap via back-door preload.
        set_idle();
        force dut.cycle_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.cycle_cnt_q;
        m_cyc = 32'hFFFF_FFFF;
        tick();
        check("cyc_wrap", bus.cycle_cnt, 32'd0);

        // Syscall counter wrap with non-matching codes.
        bus.valid = 1'b1; bus.syscall = 1'b1; bus.v0 = 32'd5;
        while (m_sys != 16'hFFFF) tick();
        tick();
        check("sys_wrap", 32'(bus.syscall_cnt), 32'd0);

        // Random traffic with occasional asynchronous resets.
        repeat (3000) begin
            rand_inputs();
            if ($urandom_range(0, 199) == 0) pulse_reset();
            tick();
        end

        // Asynchronous reset while halted with a displayed value.
        pulse_reset();
        set_idle();
        bus.valid = 1'b1; bus.syscall = 1'b1; bus.v0 = 32'd1; bus.a0 = 32'hCAFE;
        tick();
        bus.v0 = 32'd10;
        tick();
        set_idle();
        bus.we = 1'b1; bus.valid = 1'b1; bus.Rw = 5'd4;
        #2 check("pre_rst_halt", 32'(bus.halt), 32'd1);
        check("pre_rst_disp", bus.disp_data, 32'hCAFE);
        rst = 1'b0;
        #1 check("arst_halt", 32'(bus.halt), 32'd0);
        check("arst_disp", bus.disp_data, 32'd0);
        check("arst_instr", bus.instr_cnt, 32'd0);
        check("arst_cyc", bus.cycle_cnt, 32'd0);
        check("arst_sys", 32'(bus.syscall_cnt), 32'd0);
        check("arst_we", 32'(bus.wb_we), 32'd1);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
